// File: rtl/drum_pkg.sv
// Shared constants and FSM encoding for the drum step sequencer.
package drum_pkg;

    localparam int STEPS    = 32;
    localparam int NUM_MAPS = 4;
    localparam int SAMPLE_W = 3;
    localparam int DUR_W    = 10;
    localparam int STEP_W   = $clog2(STEPS);
    localparam int MAP_W    = $clog2(NUM_MAPS);
    localparam int ADDR_W   = MAP_W + STEP_W;

    localparam logic [SAMPLE_W-1:0] SAMPLE_REST = {SAMPLE_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_WAIT  = 2'd3
    } state_t;

endpackage

// File: rtl/pattern_ram.sv
// Pattern storage: NUM_MAPS x STEPS sample codes, one sync write and one sync read port.
module pattern_ram
    import drum_pkg::*;
(
    input  logic                clk,
    input  logic                i_we,
    input  logic [ADDR_W-1:0]   i_wr_addr,
    input  logic [SAMPLE_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0]   i_rd_addr,
    output logic [SAMPLE_W-1:0] o_rd_data
);

    logic [SAMPLE_W-1:0] r_mem [NUM_MAPS*STEPS];
    logic [SAMPLE_W-1:0] r_rd_data;

    // Write and read share the edge; a colliding read returns the pre-write contents.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/step_scheduler.sv
// Walks the selected drum pattern at step_ms per step and hands non-rest codes to the synth.
module step_scheduler
    import drum_pkg::*;
(
    input  logic                clk,
    input  logic                nrst,
    input  logic                i_tick_1ms,
    input  logic                i_run,
    input  logic [MAP_W-1:0]    i_map_sel,
    input  logic [DUR_W-1:0]    i_step_ms,
    input  logic                i_cfg_we,
    input  logic [MAP_W-1:0]    i_cfg_map,
    input  logic [STEP_W-1:0]   i_cfg_step,
    input  logic [SAMPLE_W-1:0] i_cfg_sample,
    output logic                o_trig_valid,
    input  logic                i_trig_ready,
    output logic [SAMPLE_W-1:0] o_trig_sample,
    output logic [STEP_W-1:0]   o_step_idx,
    output logic [MAP_W-1:0]    o_active_map,
    output logic                o_beat_pulse,
    output logic                o_overrun
);

    state_t              r_state,       w_state_nx;
    logic [DUR_W-1:0]    r_ms_cnt,      w_ms_nx;
    logic [STEP_W-1:0]   r_step_idx,    w_step_nx;
    logic [MAP_W-1:0]    r_active_map,  w_map_nx;
    logic                r_beat_pulse,  w_beat_nx;
    logic                r_trig_valid,  w_valid_nx;
    logic [SAMPLE_W-1:0] r_trig_sample, w_sample_nx;
    logic                r_overrun,     w_overrun_nx;

    logic [DUR_W-1:0]    w_step_len;
    logic [DUR_W:0]      w_ms_inc;
    logic [STEP_W-1:0]   w_step_inc;
    logic                w_boundary;
    logic [SAMPLE_W-1:0] w_rd_data;

    // The read address follows the next-step values so the code is ready during FETCH.
    pattern_ram u_ram (
        .clk       (clk),
        .i_we      (i_cfg_we),
        .i_wr_addr ({i_cfg_map, i_cfg_step}),
        .i_wr_data (i_cfg_sample),
        .i_rd_addr ({w_map_nx, w_step_nx}),
        .o_rd_data (w_rd_data)
    );

    assign w_step_len = (i_step_ms == {DUR_W{1'b0}}) ? {{(DUR_W-1){1'b0}}, 1'b1} : i_step_ms;
    assign w_ms_inc   = {1'b0, r_ms_cnt} + {{DUR_W{1'b0}}, 1'b1};
    assign w_step_inc = r_step_idx + {{(STEP_W-1){1'b0}}, 1'b1};
    assign w_boundary = i_tick_1ms && (w_ms_inc >= {1'b0, w_step_len});

    // Next-state and next-output logic for the sequencer FSM.
    always_comb begin
        w_state_nx   = r_state;
        w_ms_nx      = r_ms_cnt;
        w_step_nx    = r_step_idx;
        w_map_nx     = r_active_map;
        w_beat_nx    = 1'b0;
        w_valid_nx   = r_trig_valid;
        w_sample_nx  = r_trig_sample;
        w_overrun_nx = r_overrun;
        if (!i_run) begin
            w_state_nx   = ST_IDLE;
            w_ms_nx      = {DUR_W{1'b0}};
            w_step_nx    = {STEP_W{1'b0}};
            w_valid_nx   = 1'b0;
            w_sample_nx  = SAMPLE_REST;
            w_overrun_nx = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nx = ST_FETCH;
                    w_ms_nx    = {DUR_W{1'b0}};
                    w_step_nx  = {STEP_W{1'b0}};
                    w_map_nx   = i_map_sel;
                    w_beat_nx  = 1'b1;
                end
                default: begin
                    if (w_boundary) begin
                        // A boundary cuts the step short; an unaccepted trigger is lost.
                        w_state_nx = ST_FETCH;
                        w_ms_nx    = {DUR_W{1'b0}};
                        w_step_nx  = w_step_inc;
                        w_beat_nx  = ~w_step_inc[0];
                        w_valid_nx = 1'b0;
                        if (w_step_inc == {STEP_W{1'b0}}) begin
                            w_map_nx = i_map_sel;
                        end else begin
                            w_map_nx = r_active_map;
                        end
                        if ((r_state == ST_ISSUE) && !i_trig_ready) begin
                            w_overrun_nx = 1'b1;
                        end else begin
                            w_overrun_nx = r_overrun;
                        end
                    end else begin
                        if (i_tick_1ms) begin
                            w_ms_nx = w_ms_inc[DUR_W-1:0];
                        end else begin
                            w_ms_nx = r_ms_cnt;
                        end
                        case (r_state)
                            ST_FETCH: begin
                                if (w_rd_data != SAMPLE_REST) begin
                                    w_state_nx  = ST_ISSUE;
                                    w_valid_nx  = 1'b1;
                                    w_sample_nx = w_rd_data;
                                end else begin
                                    w_state_nx  = ST_WAIT;
                                end
                            end
                            ST_ISSUE: begin
                                if (i_trig_ready) begin
                                    w_state_nx = ST_WAIT;
                                    w_valid_nx = 1'b0;
                                end else begin
                                    w_state_nx = ST_ISSUE;
                                end
                            end
                            ST_WAIT: begin
                                w_state_nx = ST_WAIT;
                            end
                            default: begin
                                w_state_nx = ST_IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state       <= ST_IDLE;
            r_ms_cnt      <= {DUR_W{1'b0}};
            r_step_idx    <= {STEP_W{1'b0}};
            r_active_map  <= {MAP_W{1'b0}};
            r_beat_pulse  <= 1'b0;
            r_trig_valid  <= 1'b0;
            r_trig_sample <= SAMPLE_REST;
            r_overrun     <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_ms_cnt      <= w_ms_nx;
            r_step_idx    <= w_step_nx;
            r_active_map  <= w_map_nx;
            r_beat_pulse  <= w_beat_nx;
            r_trig_valid  <= w_valid_nx;
            r_trig_sample <= w_sample_nx;
            r_overrun     <= w_overrun_nx;
        end
    end

    assign o_trig_valid  = r_trig_valid;
    assign o_trig_sample = r_trig_sample;
    assign o_step_idx    = r_step_idx;
    assign o_active_map  = r_active_map;
    assign o_beat_pulse  = r_beat_pulse;
    assign o_overrun     = r_overrun;

endmodule
